path_stack: RTL and testbench
=============================

Name: path_stack

Overview:
- Capture buffer between the path-walk FSM and the VGA display module.
- Records each node index the FSM presents while walking the predecessor chain, which runs destination to source.
- Drops consecutive duplicates, since the FSM holds the source index at the end of the walk.
- Replays the stored path in reverse order (source first) to the display over a valid/ready handshake, and reports the hop count.

Parameters:
- NODE_W, 5, width of a node index.
- DEPTH, 32, number of stack entries (maximum path length in nodes).
- CNT_W, 6, width of the entry counter; must be at least log2(DEPTH)+1.

Ports:
- clk  in  1  system clock (50 MHz domain); all logic rising-edge.
- sys_reset  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear; driven high while the FSM is in DEST_INP.
- wr_en  in  1  capture strobe, asserted during DEST_READ and RECURSION.
- wr_index  in  NODE_W  node index to capture (FSM predecessor_addr).
- replay_start  in  1  single-cycle pulse requesting replay.
- rd_ready  in  1  consumer accepts the current rd_index.
- rd_valid  out  1  rd_index valid.
- rd_index  out  NODE_W  replayed node index.
- rd_last  out  1  current beat is the final (destination) entry.
- hop_count  out  CNT_W  number of edges in the path: count-1 when count>0, else 0.
- overflow  out  1  sticky flag: a push was dropped because the stack was full.
- busy  out  1  high in REPLAY.
- done  out  1  high in DONE.

Behaviour:
- Reset (sys_reset low, asynchronous): state IDLE, count=0, rd_ptr=0, last_idx=0. All outputs 0.
- Storage is a register array mem[0..DEPTH-1]. count holds the number of valid entries.
- States:
  - IDLE: capture.
  - REPLAY: output entries.
  - DONE: replay finished, contents retained.
- Priority each cycle: sys_reset > clr > state logic.
- clr (any state):
  - Next cycle: state IDLE, count=0, overflow=0, rd_valid=0.
  - Memory contents are don't-care.
  - A simultaneous wr_en or replay_start is ignored.
- IDLE capture (wr_en=1):
  - Push when count==0, or when wr_index != last_idx.
  - A push writes mem[count]=wr_index, increments count and sets last_idx=wr_index.
  - An equal consecutive index is discarded silently.
  - Push with count==DEPTH: data dropped, count unchanged, overflow set to 1.
  - A duplicate at full is not an overflow.
  - wr_en outside IDLE is ignored.
- IDLE replay_start:
  - count>0: next state REPLAY, rd_ptr=count-1.
  - count==0: next state DONE directly; rd_valid never asserts.
  - A simultaneous wr_en is ignored; replay wins.
- REPLAY:
  - rd_valid=1 from the first cycle in REPLAY, i.e. one cycle after replay_start.
  - rd_index=mem[rd_ptr], registered output.
  - rd_last=1 when rd_ptr==0.
  - Beat transfers on a cycle with rd_valid && rd_ready; then rd_ptr decrements.
  - When the transferring beat has rd_last=1: next state DONE, rd_valid=0.
  - While rd_ready=0, rd_index and rd_last hold stable.
  - Throughput is one beat per cycle with rd_ready held high.
- DONE:
  - Contents and count retained; rd_valid=0.
  - replay_start restarts REPLAY from rd_ptr=count-1, so replay is non-destructive.
  - wr_en is ignored.
- hop_count is combinational from count and is valid in all states.
- Reset asserted mid-replay aborts immediately with all outputs 0. clr mid-replay returns to IDLE the next cycle.
- Widths: count is compared against DEPTH at CNT_W bits. rd_ptr is CNT_W-1 bits and never wraps below 0, because the transition to DONE occurs on the rd_last beat.

Test Plan:
1. Capture and replay:
   - Stimulus: reset; wr_en sequence 7,4,4,2,0,0 (source 0); replay_start; rd_ready=1.
   - Required: beats 0,2,4,7 on consecutive cycles; rd_last on 7; hop_count=3; done=1 after the last beat.
2. Backpressure:
   - Stimulus: same path; rd_ready toggles 1,0,0,1,1,0,1.
   - Required: rd_index stable through stalls; exactly 4 transfers; order 0,2,4,7.
3. Overflow:
   - Stimulus: 33 distinct pushes (indices alternate 1,2).
   - Required: count=32; overflow=1; hop_count=31. Replay yields the first 32 entries reversed.
4. Empty replay:
   - Stimulus: replay_start with count=0.
   - Required: done=1 the next cycle; rd_valid never 1; hop_count=0.
5. Repeat and clear:
   - Stimulus: after DONE, replay_start again; then clr during the second beat.
   - Required: the second replay is identical to the first. After clr: IDLE, rd_valid=0, count=0, overflow=0.
6. Async reset:
   - Stimulus: drop sys_reset mid-REPLAY with no clock edge.
   - Required: rd_valid, busy, done and hop_count are 0 immediately; IDLE after release.

Source files
------------

// File: rtl/path_stack.sv
// Capture stack between the path-walk FSM and the display: records the predecessor
// chain (destination first), drops repeated indices, and replays it source first.
`timescale 1ns/1ps
module path_stack #(
    parameter int NODE_W = 5,
    parameter int DEPTH  = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              sys_reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [NODE_W-1:0] wr_index,
    input  logic              replay_start,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [NODE_W-1:0] rd_index,
    output logic              rd_last,
    output logic [CNT_W-1:0]  hop_count,
    output logic              overflow,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);
    // Read port: a beat is offered while rd_valid is high and moves on the
    // rising edge where rd_valid && rd_ready; rd_index/rd_last hold until then.

    localparam int PTR_W = CNT_W - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REPLAY = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [NODE_W-1:0]   last_idx_q, last_idx_d;
    logic [NODE_W-1:0]   rd_index_q, rd_index_d;
    logic                rd_last_q, rd_last_d;
    logic                overflow_q, overflow_d;
    logic [NODE_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic                load_top;
    logic [PTR_W-1:0]    top_ptr;
    logic [PTR_W-1:0]    next_ptr;
    logic                is_full;
    logic                is_new;

    assign top_ptr  = PTR_W'(count_q - CNT_W'(1));
    assign next_ptr = rd_ptr_q - PTR_W'(1);
    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign is_new   = (count_q == '0) || (wr_index != last_idx_q);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        last_idx_d = last_idx_q;
        rd_index_d = rd_index_q;
        rd_last_d  = rd_last_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        load_top   = 1'b0;

        if (clr) begin
            state_d    = IDLE;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (replay_start) begin
                        if (count_q != '0) begin
                            state_d  = REPLAY;
                            load_top = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end else if (wr_en && is_new) begin
                        // A distinct index arriving at full capacity is lost.
                        if (is_full) begin
                            overflow_d = 1'b1;
                        end else begin
                            mem_we     = 1'b1;
                            count_d    = count_q + CNT_W'(1);
                            last_idx_d = wr_index;
                        end
                    end
                end
                REPLAY: begin
                    if (rd_ready) begin
                        if (rd_last_q) begin
                            state_d = DONE;
                        end else begin
                            rd_ptr_d   = next_ptr;
                            rd_index_d = mem_q[next_ptr];
                            rd_last_d  = (next_ptr == '0);
                        end
                    end
                end
                DONE: begin
                    if (replay_start && (count_q != '0)) begin
                        state_d  = REPLAY;
                        load_top = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Entering REPLAY presents the newest entry, i.e. the path source.
            if (load_top) begin
                rd_ptr_d   = top_ptr;
                rd_index_d = mem_q[top_ptr];
                rd_last_d  = (top_ptr == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            last_idx_q <= '0;
            rd_index_q <= '0;
            rd_last_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            last_idx_q <= last_idx_d;
            rd_index_q <= rd_index_d;
            rd_last_q  <= rd_last_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[count_q[PTR_W-1:0]] <= wr_index;
        end
    end

    assign rd_valid  = (state_q == REPLAY);
    assign busy      = (state_q == REPLAY);
    assign done      = (state_q == DONE);
    assign rd_index  = rd_index_q;
    assign rd_last   = rd_last_q;
    assign overflow  = overflow_q;
    assign hop_count = (count_q != '0) ? (count_q - CNT_W'(1)) : '0;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_path_stack.sv
// Bench for path_stack: table-driven capture checks plus a beat scoreboard fed from
// a reference list of stored entries, with hand sequences for stall, clear and reset.
`timescale 1ns/1ps
module tb_path_stack;
    localparam int NODE_W = 5;
    localparam int DEPTH  = 32;
    localparam int CNT_W  = 6;
    localparam logic [1:0] ST_IDLE = 2'd0;

    logic              clk = 1'b0;
    logic              sys_reset = 1'b0;
    logic              clr = 1'b0;
    logic              wr_en = 1'b0;
    logic [NODE_W-1:0] wr_index = '0;
    logic              replay_start = 1'b0;
    logic              rd_ready = 1'b1;
    logic              rd_valid;
    logic [NODE_W-1:0] rd_index;
    logic              rd_last;
    logic [CNT_W-1:0]  hop_count;
    logic              overflow;
    logic              busy;
    logic              done;
    logic [1:0]        dbg_state;

    path_stack #(.NODE_W(NODE_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .sys_reset(sys_reset), .clr(clr), .wr_en(wr_en),
        .wr_index(wr_index), .replay_start(replay_start), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_index(rd_index), .rd_last(rd_last),
        .hop_count(hop_count), .overflow(overflow), .busy(busy), .done(done),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int beats    = 0;
    int valid_seen = 0;

    logic [NODE_W:0]   exp_q[$];
    logic [NODE_W-1:0] model_q[$];
    logic              rdy_pat[16];
    int                rdy_len = 0;

    logic              stall_prev = 1'b0;
    logic [NODE_W:0]   held_beat = '0;

    typedef struct {
        logic [NODE_W-1:0] idx;
        logic [CNT_W-1:0]  exp_hop;
        logic              exp_ovf;
    } vec_t;
    vec_t cap_tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Beat monitor: scoreboard pop on each transfer, stability check across stalls.
    always @(negedge clk) begin
        if (sys_reset) begin
            if (rd_valid) valid_seen++;
            if (rd_valid && stall_prev)
                check("stall_hold", {rd_last, rd_index}, held_beat);
            if (rd_valid && rd_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {rd_last, rd_index}, 32'hFFFF_FFFF);
                end else begin
                    check("beat", {rd_last, rd_index}, exp_q.pop_front());
                end
            end
            stall_prev = rd_valid && !rd_ready;
            held_beat  = {rd_last, rd_index};
        end
    end

    task automatic push(input logic [NODE_W-1:0] idx);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_index = idx;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic do_clr();
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic load_expected();
        for (int i = model_q.size() - 1; i >= 0; i--)
            exp_q.push_back({(i == 0), model_q[i]});
    endtask

    task automatic run_replay(input int max_cyc, output int busy_cyc, output int wait_cyc);
        int k;
        busy_cyc = 0;
        wait_cyc = 0;
        k = 0;
        @(posedge clk); #1;
        replay_start = 1'b1;
        @(posedge clk); #1;
        replay_start = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            rd_ready = (k < rdy_len) ? rdy_pat[k] : 1'b1;
            k++;
            @(negedge clk);
            wait_cyc++;
            if (done) break;
            if (busy) busy_cyc++;
            @(posedge clk); #1;
        end
        rd_ready = 1'b1;
        check("replay_done", done, 1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int bc, wc, b0, v0;

        cap_tbl[0] = '{idx: 5'd7, exp_hop: 6'd0, exp_ovf: 1'b0};
        cap_tbl[1] = '{idx: 5'd4, exp_hop: 6'd1, exp_ovf: 1'b0};
        cap_tbl[2] = '{idx: 5'd4, exp_hop: 6'd1, exp_ovf: 1'b0};
        cap_tbl[3] = '{idx: 5'd2, exp_hop: 6'd2, exp_ovf: 1'b0};
        cap_tbl[4] = '{idx: 5'd0, exp_hop: 6'd3, exp_ovf: 1'b0};
        cap_tbl[5] = '{idx: 5'd0, exp_hop: 6'd3, exp_ovf: 1'b0};

        // Reset values
        #1;
        check("rst_valid", rd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hop", hop_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_index", rd_index, 0);
        check("rst_last", rd_last, 0);
        repeat (2) @(negedge clk);
        sys_reset = 1'b1;

        // Capture and replay at full rate
        for (int i = 0; i < 6; i++) begin
            push(cap_tbl[i].idx);
            check($sformatf("cap_hop[%0d]", i), hop_count, cap_tbl[i].exp_hop);
            check($sformatf("cap_ovf[%0d]", i), overflow, cap_tbl[i].exp_ovf);
        end
        model_q = '{5'd7, 5'd4, 5'd2, 5'd0};
        load_expected();
        rdy_len = 0;
        b0 = beats;
        run_replay(20, bc, wc);
        check("t1_beats", beats - b0, 4);
        check("t1_busy_cycles", bc, 4);
        check("t1_latency", wc, 5);
        check("t1_hop", hop_count, 3);

        // Repeat replay is identical
        load_expected();
        b0 = beats;
        run_replay(20, bc, wc);
        check("t5_repeat_beats", beats - b0, 4);

        // Backpressure
        rdy_pat[0] = 1; rdy_pat[1] = 0; rdy_pat[2] = 0; rdy_pat[3] = 1;
        rdy_pat[4] = 1; rdy_pat[5] = 0; rdy_pat[6] = 1;
        rdy_len = 7;
        load_expected();
        b0 = beats;
        run_replay(30, bc, wc);
        rdy_len = 0;
        check("t2_transfers", beats - b0, 4);
        check("t2_busy_cycles", bc, 7);

        // Clear during the second beat
        exp_q.push_back({1'b0, 5'd0});
        @(posedge clk); #1;
        replay_start = 1'b1;
        @(posedge clk); #1;
        replay_start = 1'b0;
        rd_ready = 1'b1;
        @(posedge clk); #1;
        clr = 1'b1;
        rd_ready = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
        rd_ready = 1'b1;
        check("t5_clr_valid", rd_valid, 0);
        check("t5_clr_state", dbg_state, ST_IDLE);
        check("t5_clr_hop", hop_count, 0);
        check("t5_clr_ovf", overflow, 0);
        check("t5_clr_queue", exp_q.size(), 0);

        // Overflow
        model_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            push((i % 2 == 0) ? 5'd1 : 5'd2);
            model_q.push_back((i % 2 == 0) ? 5'd1 : 5'd2);
        end
        check("t3_full_hop", hop_count, 31);
        check("t3_full_ovf", overflow, 0);
        push(5'd2);
        check("t3_dup_at_full_ovf", overflow, 0);
        push(5'd1);
        check("t3_ovf", overflow, 1);
        check("t3_ovf_hop", hop_count, 31);
        load_expected();
        b0 = beats;
        run_replay(60, bc, wc);
        check("t3_beats", beats - b0, 32);
        check("t3_ovf_sticky", overflow, 1);
        do_clr();
        check("t3_clr_ovf", overflow, 0);
        check("t3_clr_hop", hop_count, 0);

        // clr wins over a simultaneous wr_en; then empty replay
        @(posedge clk); #1;
        clr = 1'b1; wr_en = 1'b1; wr_index = 5'd9;
        @(posedge clk); #1;
        clr = 1'b0; wr_en = 1'b0;
        check("t4_clr_wr_hop", hop_count, 0);
        v0 = valid_seen;
        run_replay(10, bc, wc);
        check("t4_latency", wc, 1);
        check("t4_busy_cycles", bc, 0);
        check("t4_no_valid", valid_seen - v0, 0);
        check("t4_hop", hop_count, 0);

        // Async reset mid-replay
        do_clr();
        push(5'd3);
        push(5'd6);
        push(5'd8);
        @(posedge clk); #1;
        replay_start = 1'b1;
        @(posedge clk); #1;
        replay_start = 1'b0;
        rd_ready = 1'b0;
        @(negedge clk);
        check("t6_pre_busy", busy, 1);
        #2;
        sys_reset = 1'b0;
        #1;
        check("t6_valid", rd_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_hop", hop_count, 0);
        @(negedge clk);
        sys_reset = 1'b1;
        stall_prev = 1'b0;
        rd_ready = 1'b1;
        @(posedge clk); #1;
        check("t6_state_idle", dbg_state, ST_IDLE);
        check("t6_valid_after", rd_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
